// File: rtl/io_bus_bridge.sv
// rtl/io_bus_bridge.sv - M-stage bridge running request/acknowledge transactions to the IO region
module io_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IO_ADDR_W      = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_io_en_m,
  input  logic [31:0]          i_effective_addr_m,
  input  logic                 i_mem_read_m,
  input  logic                 i_mem_write_m,
  input  logic [31:0]          i_wdata_m,
  output logic                 o_stall_m,
  output logic [31:0]          o_rdata_m,
  output logic                 o_rdata_valid_m,
  output logic                 o_bus_err_m,
  output logic                 o_io_req,
  output logic                 o_io_we,
  output logic [IO_ADDR_W-1:0] o_io_addr,
  output logic [31:0]          o_io_wdata,
  input  logic                 i_io_ack,
  input  logic [31:0]          i_io_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       start;
  logic       unused_addr_hi;

  assign start          = i_io_en_m & (i_mem_read_m | i_mem_write_m);
  assign unused_addr_hi = ^i_effective_addr_m[31:IO_ADDR_W];

  // Gated by reset so the pipeline is never frozen while the bridge is held in reset.
  assign o_stall_m = i_rst_n & (((state == IDLE) & start) | (state == REQ));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      o_io_req        <= 1'b0;
      o_io_we         <= 1'b0;
      o_io_addr       <= '0;
      o_io_wdata      <= 32'h0;
      o_rdata_m       <= 32'h0;
      o_rdata_valid_m <= 1'b0;
      o_bus_err_m     <= 1'b0;
    end else begin
      o_rdata_valid_m <= 1'b0;
      o_bus_err_m     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            cnt        <= 8'd0;
            o_io_req   <= 1'b1;
            o_io_we    <= i_mem_write_m;
            o_io_addr  <= i_effective_addr_m[IO_ADDR_W-1:0];
            o_io_wdata <= i_wdata_m;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          // Ack takes priority over a timeout landing in the same cycle.
          if (i_io_ack) begin
            state    <= DONE;
            o_io_req <= 1'b0;
            if (!o_io_we) begin
              o_rdata_m       <= i_io_rdata;
              o_rdata_valid_m <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            state       <= DONE;
            o_io_req    <= 1'b0;
            o_bus_err_m <= 1'b1;
            if (!o_io_we) begin
              o_rdata_m <= 32'h0;
            end
          end
        end
        DONE: begin
          // The finishing instruction is still in M this cycle; never retrigger here.
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          o_io_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb/tb_io_bus_bridge.sv - directed self-checking bench for io_bus_bridge
module tb_io_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_en;
  logic [31:0] eff_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_err;
  logic        io_req;
  logic        io_we;
  logic [19:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;

  int checks   = 0;
  int failures = 0;

  io_bus_bridge #(.TIMEOUT_CYCLES(16), .IO_ADDR_W(20)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_io_en_m          (io_en),
    .i_effective_addr_m (eff_addr),
    .i_mem_read_m       (mem_read),
    .i_mem_write_m      (mem_write),
    .i_wdata_m          (wdata),
    .o_stall_m          (stall),
    .o_rdata_m          (rdata),
    .o_rdata_valid_m    (rdata_valid),
    .o_bus_err_m        (bus_err),
    .o_io_req           (io_req),
    .o_io_we            (io_we),
    .o_io_addr          (io_addr),
    .o_io_wdata         (io_wdata),
    .i_io_ack           (io_ack),
    .i_io_rdata         (io_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    io_en = 0; mem_read = 0; mem_write = 0; eff_addr = 0; wdata = 0;
    io_ack = 0; io_rdata = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_inputs();
    io_en = 1; mem_read = 1; eff_addr = 32'h000C0000;
    #12;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall act=%b exp=0", stall); end
    checks++; if ({io_req, io_we, rdata_valid, bus_err} !== 4'b0) begin failures++; $display("FAIL reset_ctrl act=%b exp=0000", {io_req, io_we, rdata_valid, bus_err}); end
    checks++; if (io_addr !== 20'h0 || io_wdata !== 32'h0 || rdata !== 32'h0) begin failures++; $display("FAIL reset_data act=%h/%h/%h exp=0/0/0", io_addr, io_wdata, rdata); end
    clear_inputs();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_read_single;
    io_en = 1; mem_read = 1; eff_addr = 32'h000C0010; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rd1_stall_T act=%b exp=1", stall); end
    tick(); // T+1
    checks++; if (io_req !== 1'b1 || stall !== 1'b1 || io_we !== 1'b0) begin failures++; $display("FAIL rd1_req act=%b%b%b exp=110", io_req, stall, io_we); end
    checks++; if (io_addr !== 20'hC0010) begin failures++; $display("FAIL rd1_addr act=%h exp=c0010", io_addr); end
    io_ack = 1; io_rdata = 32'hA5A51234;
    tick(); // T+2
    io_ack = 0; io_rdata = 0; #1;
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hA5A51234) begin failures++; $display("FAIL rd1_data act=%b/%h exp=1/a5a51234", rdata_valid, rdata); end
    checks++; if (stall !== 1'b0 || io_req !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL rd1_done act=%b%b%b exp=000", stall, io_req, bus_err); end
    clear_inputs();
    tick();
    checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL rd1_pulse act=%b exp=0", rdata_valid); end
  endtask

  task automatic test_write_delayed;
    int stall_cnt = 0;
    int bad = 0;
    io_en = 1; mem_write = 1; wdata = 32'h000000FF; eff_addr = 32'h000C0020; #1;
    if (stall) stall_cnt++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      wdata = 32'hDEADBEEF;
      if (stall) stall_cnt++;
      if (io_req !== 1'b1 || io_we !== 1'b1 || io_wdata !== 32'h000000FF || io_addr !== 20'hC0020) bad++;
      if (i == 5) io_ack = 1;
    end
    tick(); // T+6 DONE
    io_ack = 0; #1;
    if (stall) stall_cnt++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL wr_hold act=%0d bad cycles exp=0", bad); end
    checks++; if (stall_cnt !== 6) begin failures++; $display("FAIL wr_stall_cnt act=%0d exp=6", stall_cnt); end
    checks++; if (rdata_valid !== 1'b0 || bus_err !== 1'b0 || io_req !== 1'b0) begin failures++; $display("FAIL wr_done act=%b%b%b exp=000", rdata_valid, bus_err, io_req); end
    checks++; if (rdata !== 32'hA5A51234) begin failures++; $display("FAIL wr_rdata_kept act=%h exp=a5a51234", rdata); end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout;
    int req_cnt = 0;
    int stall_cnt = 0;
    io_en = 1; mem_read = 1; eff_addr = 32'h000C0030; #1;
    if (stall) stall_cnt++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (io_req) req_cnt++;
      if (stall) stall_cnt++;
    end
    tick(); // T+17
    checks++; if (req_cnt !== 16) begin failures++; $display("FAIL to_req_cycles act=%0d exp=16", req_cnt); end
    checks++; if (stall_cnt !== 17 || stall !== 1'b0) begin failures++; $display("FAIL to_stall act=%0d/%b exp=17/0", stall_cnt, stall); end
    checks++; if (bus_err !== 1'b1 || rdata_valid !== 1'b0) begin failures++; $display("FAIL to_err act=%b/%b exp=1/0", bus_err, rdata_valid); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL to_rdata act=%h exp=0", rdata); end
    clear_inputs();
    tick();
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_pulse act=%b exp=0", bus_err); end
    io_en = 1; mem_read = 1; eff_addr = 32'h000C0034; #1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 16) begin io_ack = 1; io_rdata = 32'h600DF00D; end
    end
    tick(); // T+17
    io_ack = 0; io_rdata = 0; #1;
    checks++; if (rdata_valid !== 1'b1 || bus_err !== 1'b0 || rdata !== 32'h600DF00D) begin failures++; $display("FAIL to_ack_last act=%b/%b/%h exp=1/0/600df00d", rdata_valid, bus_err, rdata); end
    clear_inputs();
    tick();
  endtask

  task automatic test_non_io;
    io_en = 0; mem_read = 1; eff_addr = 32'h000C0040;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b0 || io_req !== 1'b0) begin failures++; $display("FAIL nonio_%0d act=%b%b exp=00", i, stall, io_req); end
      tick();
      mem_write = (i == 0);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_read_write_both;
    io_en = 1; mem_read = 1; mem_write = 1; wdata = 32'h12345678; eff_addr = 32'hFFFABCDE; #1;
    tick(); // T+1
    checks++; if (io_we !== 1'b1 || io_wdata !== 32'h12345678 || io_addr !== 20'hABCDE) begin failures++; $display("FAIL rw_latch act=%b/%h/%h exp=1/12345678/abcde", io_we, io_wdata, io_addr); end
    io_ack = 1; io_rdata = 32'h11111111;
    tick(); // T+2
    io_ack = 0; #1;
    checks++; if (rdata_valid !== 1'b0 || bus_err !== 1'b0 || rdata !== 32'h600DF00D) begin failures++; $display("FAIL rw_done act=%b/%b/%h exp=0/0/600df00d", rdata_valid, bus_err, rdata); end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    int req_cycles = 0;
    io_en = 1; mem_read = 1; eff_addr = 32'h000C0040; #1;
    tick(); // T+1
    if (io_req) req_cycles++;
    io_ack = 1; io_rdata = 32'h0000AAAA;
    tick(); // T+2 DONE, inputs still held
    io_ack = 0; #1;
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h0000AAAA || stall !== 1'b0) begin failures++; $display("FAIL b2b_first act=%b/%h/%b exp=1/0000aaaa/0", rdata_valid, rdata, stall); end
    tick(); // T+3 second start
    eff_addr = 32'h000C0044; #1;
    checks++; if (stall !== 1'b1 || io_req !== 1'b0) begin failures++; $display("FAIL b2b_restart act=%b%b exp=10", stall, io_req); end
    tick(); // T+4
    if (io_req) req_cycles++;
    checks++; if (io_addr !== 20'hC0044) begin failures++; $display("FAIL b2b_addr act=%h exp=c0044", io_addr); end
    io_ack = 1; io_rdata = 32'h0000BBBB;
    tick(); // T+5
    clear_inputs(); #1;
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h0000BBBB) begin failures++; $display("FAIL b2b_second act=%b/%h exp=1/0000bbbb", rdata_valid, rdata); end
    tick();
    if (io_req) req_cycles++;
    checks++; if (req_cycles !== 2 || stall !== 1'b0) begin failures++; $display("FAIL b2b_count act=%0d/%b exp=2/0", req_cycles, stall); end
  endtask

  task automatic test_spurious_ack;
    io_ack = 1; io_rdata = 32'hFFFFFFFF;
    tick(); tick(); tick();
    checks++; if (io_req !== 1'b0 || rdata_valid !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0000BBBB) begin failures++; $display("FAIL spurious act=%b%b%b/%h exp=000/0000bbbb", io_req, rdata_valid, stall, rdata); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    io_en = 1; mem_write = 1; wdata = 32'h0000CAFE; eff_addr = 32'h000C0050; #1;
    tick(); tick(); tick(); // REQ cycle 3
    checks++; if (io_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre act=%b exp=1", io_req); end
    #2 rst_n = 0;
    #1;
    checks++; if (io_req !== 1'b0 || stall !== 1'b0 || io_we !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl act=%b%b%b exp=000", io_req, stall, io_we); end
    checks++; if (io_addr !== 20'h0 || io_wdata !== 32'h0 || rdata !== 32'h0 || rdata_valid !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL rst_mid_data act=%h/%h/%h/%b%b exp=0/0/0/00", io_addr, io_wdata, rdata, rdata_valid, bus_err); end
    clear_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
    checks++; if (stall !== 1'b0 || io_req !== 1'b0) begin failures++; $display("FAIL rst_mid_idle act=%b%b exp=00", stall, io_req); end
    io_en = 1; mem_read = 1; eff_addr = 32'h000C0060; #1;
    tick();
    checks++; if (io_req !== 1'b1 || io_addr !== 20'hC0060) begin failures++; $display("FAIL rst_mid_after act=%b/%h exp=1/c0060", io_req, io_addr); end
    io_ack = 1; io_rdata = 32'h00C0FFEE;
    tick();
    clear_inputs(); #1;
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h00C0FFEE) begin failures++; $display("FAIL rst_mid_read act=%b/%h exp=1/00c0ffee", rdata_valid, rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_write_delayed();
    test_timeout();
    test_non_io();
    test_read_write_both();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
